// File: rtl/div_const_pkg.sv
// Shared constants and state encoding for the divide-by-5 family and its reconstructor.
package div_const_pkg;

    localparam int unsigned DIVISOR = 5;
    localparam int unsigned REM_W   = 3;
    localparam int unsigned CARRY_W = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/mul5_res_recon_if.sv
// Operand/result handshake bundle for mul5_res_recon.
interface mul5_res_recon_if
    import div_const_pkg::*;
#(
    parameter int unsigned W = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     q;
    logic [REM_W-1:0] r;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     x;
    logic             ovf;
    logic             rem_err;

    modport slave (
        input  in_valid, q, r, out_ready,
        output in_ready, out_valid, x, ovf, rem_err
    );

    modport master (
        output in_valid, q, r, out_ready,
        input  in_ready, out_valid, x, ovf, rem_err
    );

endinterface

// File: rtl/mul5_res_recon_chunk.sv
// One combinational step of 5*q + r: 5*n + c = c_out * 2^CHUNK + digit.
module mul5_chunk
    import div_const_pkg::*;
#(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0]   n,
    input  logic [CARRY_W-1:0] c,
    output logic [CHUNK-1:0]   digit,
    output logic [CARRY_W-1:0] c_out
);

    localparam int unsigned SW = CHUNK + CARRY_W;

    logic [SW-1:0] n_ext;
    logic [SW-1:0] c_ext;
    logic [SW-1:0] s;

    always_comb begin
        n_ext = SW'(n);
        c_ext = SW'(c);
        // 5*n as (n << 2) + n; max 5*(2^CHUNK-1) + 7 fits in CHUNK+3 bits
        s     = (n_ext << 2) + n_ext + c_ext;
        digit = s[CHUNK-1:0];
        c_out = s[SW-1:CHUNK];
    end

endmodule

// File: rtl/mul5_res_recon.sv
// Iterative reconstruction x = 5*q + r, LSB-first, CHUNK quotient bits per cycle.
module mul5_res_recon
    import div_const_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned CHUNK = 4
) (
    input  logic              clk,
    input  logic              rst,
    mul5_res_recon_if.slave   bus
);

    localparam int unsigned    Steps    = W / CHUNK;
    localparam int unsigned    CntW     = (Steps > 1) ? $clog2(Steps) : 1;
    localparam logic [CntW-1:0] LastStep = CntW'(Steps - 1);

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]       qs_q, qs_d;
    logic [W-1:0]       res_q, res_d;
    logic [CARRY_W-1:0] c_q, c_d;
    logic               ovf_q, ovf_d;
    logic               rem_err_q, rem_err_d;

    logic [CHUNK-1:0]   digit;
    logic [CARRY_W-1:0] c_next;

    mul5_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .n     (qs_q[CHUNK-1:0]),
        .c     (c_q),
        .digit (digit),
        .c_out (c_next)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        qs_d      = qs_q;
        res_d     = res_q;
        c_d       = c_q;
        ovf_d     = ovf_q;
        rem_err_d = rem_err_q;

        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    qs_d      = bus.q;
                    c_d       = bus.r;
                    rem_err_d = (bus.r >= REM_W'(DIVISOR));
                    ovf_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                qs_d  = qs_q >> CHUNK;
                res_d = {digit, res_q[W-1:CHUNK]};
                c_d   = c_next;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastStep) begin
                    // Any carry left after the top chunk is weight 2^W and beyond
                    ovf_d   = (c_next != '0);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            qs_q      <= '0;
            res_q     <= '0;
            c_q       <= '0;
            ovf_q     <= 1'b0;
            rem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            qs_q      <= qs_d;
            res_q     <= res_d;
            c_q       <= c_d;
            ovf_q     <= ovf_d;
            rem_err_q <= rem_err_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.x         = res_q;
    assign bus.ovf       = ovf_q;
    assign bus.rem_err   = rem_err_q;

endmodule

// File: doc/mul5_res_recon.md
# mul5_res_recon

Inverse of the divide-by-5 quotient/remainder datapath: reconstructs the dividend x = 5·q + r from a 32-bit quotient and 3-bit remainder. It serves as the golden-direction checker and decoder behind the constant-division units: divider output goes in, the original operand comes out for comparison. Computation is iterative, LSB-first, CHUNK bits per cycle, with valid/ready handshakes on both sides.

## Interface
- W, 32, quotient/result width; must be a multiple of CHUNK
- CHUNK, 4, quotient bits consumed per cycle; legal values 1, 2, 4, 8
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair
- q  in  W  quotient
- r  in  3  remainder
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- x  out  W  reconstructed dividend, low W bits of 5·q + r
- ovf  out  1  5·q + r ≥ 2^W
- rem_err  out  1  r ≥ 5, an illegal remainder for divisor 5

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid is high, capture q into shift register qs, load carry c ← r, set rem_err ← (r ≥ 5), clear the step counter, and go to RUN.
- RUN: in_ready=0. Each cycle:
  - take n = qs[CHUNK-1:0] and compute s = 5·n + c;
  - shift s[CHUNK-1:0] into the top of the result register (LSB-first assembly);
  - set c ← s >> CHUNK and shift qs right by CHUNK.
  - After W/CHUNK steps, go to DONE.
- Carry fits in 3 bits for every legal CHUNK. The bound is c ≤ 7, so s < 5·2^CHUNK + 8.
- On entering DONE: ovf ← (c ≠ 0), out_valid=1.
- DONE: x, ovf and rem_err are held stable while out_ready=0. When out_ready=1, go to IDLE.
- A new operand cannot be accepted in the DONE→IDLE cycle. It can be accepted on the next cycle.
- rem_err does not suppress computation. x is still the low W bits of 5·q + r.
- in_valid while busy is ignored. No operand is lost, because in_ready=0 during that time.

## Timing
- Reset values: in_ready=1, out_valid=0, x=0, ovf=0, rem_err=0, state=IDLE, counter=0, carry=0.
- Accept handshake on edge T. The RUN steps occur on edges T+1 … T+W/CHUNK. out_valid is high after edge T+W/CHUNK.
  - With defaults this is 8 cycles of latency from accept to out_valid.
- Minimum initiation interval is W/CHUNK + 2 cycles:
  - 1 accept cycle;
  - W/CHUNK RUN cycles;
  - at least 1 DONE cycle.
- out_valid/out_ready follow standard rules: once asserted, out_valid stays high and the outputs do not change until the handshake completes.
- Asynchronous rst mid-RUN or in DONE aborts the operation. All outputs return to their reset values immediately. The partial result is discarded.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Structure
- Shared package `div_const_pkg`: DIVISOR=5, REM_W=3, CARRY_W=3, and the state enum {IDLE, RUN, DONE}.
- One natural sub-module: `mul5_chunk`, a purely combinational step.
  - Inputs: n[CHUNK], c[3].
  - Outputs: digit[CHUNK] and c_out[3], where 5·n + c = c_out·2^CHUNK + digit.
  - Verified standalone by exhaustive test.
- Top level holds the FSM, step counter, qs shift register, result shift register and flags.

## Test plan
- Reset, then q=0, r=0 → after 8 cycles x=0x00000000, ovf=0, rem_err=0. Also check out_valid and all outputs are low during and after reset.
- q=0x12345678, r=3 → x=0x5B05B05B, ovf=0, rem_err=0. Latency is exactly 8 cycles from accept.
- q=858993459 (0x33333333), r=0 → x=0xFFFFFFFF, ovf=0. Then the same q with r=1 → x=0x00000000, ovf=1.
- q=1, r=6 → x=0x0000000B, rem_err=1, ovf=0.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0, and an extra in_valid pulse is not accepted. Then release → one handshake, return to IDLE.
- Assert rst at step 4 of RUN → outputs go to reset values immediately. Next operand q=2, r=4 → x=14 after a full 8 cycles.
- Random: 10k pairs across CHUNK ∈ {1, 2, 4, 8}, checked against 5·q + r computed at 35 bits, split into x and ovf.
